// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles a 32-bit little-endian instruction from four
// byte reads on a shared memory port and holds it for the IF/ID hand-off.
module if_fetch #(
  parameter int ADDR_W   = 17,
  parameter int STALL_W  = 6,
  parameter int STALL_IF = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic [31:0]        pc_i,
  input  logic               mem_busy_i,
  input  logic [7:0]         mem_din_i,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               mem_rd_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_inst_o,
  output logic               if_valid_o,
  output logic               stallreq_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_RD3, S_RD4, S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0][7:0] byte_q, byte_d;
  logic [31:0]     if_pc_q, if_pc_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic            if_valid_q, if_valid_d;

  logic              issue;
  logic              accept;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offset;
  logic              unused_stall_bits;

  assign accept            = ~stall_i[STALL_IF];
  assign unused_stall_bits = ^stall_i;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    issue      = 1'b0;
    offset     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!flush_i && !mem_busy_i) begin
          issue   = 1'b1;
          addr_d  = pc_i;
          state_d = S_RD1;
        end
      end
      S_RD1: begin
        byte_d[0] = mem_din_i;
        issue     = 1'b1;
        offset    = ADDR_W'(1);
        state_d   = S_RD2;
      end
      S_RD2: begin
        byte_d[1] = mem_din_i;
        issue     = 1'b1;
        offset    = ADDR_W'(2);
        state_d   = S_RD3;
      end
      S_RD3: begin
        byte_d[2] = mem_din_i;
        issue     = 1'b1;
        offset    = ADDR_W'(3);
        state_d   = S_RD4;
      end
      S_RD4: begin
        if_inst_d  = {mem_din_i, byte_q[2], byte_q[1], byte_q[0]};
        if_pc_d    = addr_q;
        if_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (accept) begin
          if_valid_d = 1'b0;
          if (mem_busy_i) begin
            state_d = S_IDLE;
          end else begin
            // Back-to-back: byte 0 of the next instruction goes out in the hand-off cycle.
            issue   = 1'b1;
            addr_d  = pc_i;
            state_d = S_RD1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A taken branch wins over everything, including completion in RD4.
    if (flush_i) begin
      issue      = 1'b0;
      addr_d     = addr_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = 1'b0;
      state_d    = S_IDLE;
    end
  end

  assign base       = (state_q == S_IDLE || state_q == S_HOLD) ? pc_i[ADDR_W-1:0]
                                                               : addr_q[ADDR_W-1:0];
  assign mem_rd_o   = issue & ~rst;
  assign mem_addr_o = mem_rd_o ? base + offset : '0;
  assign stallreq_o = (state_q != S_HOLD);

  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;
  assign if_valid_o = if_valid_q;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      // NOTE: the small byte buffer is reset too, so a post-reset dump never shows stale bytes.
      byte_q     <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

endmodule
